key_search_scheduler: RTL and testbench

Round-robin key dispatcher for the parallel RC4 brute-force search. Sits between the top-level control and the NUM_CORES decrypt cores: it hands each idle core the next untried secret key, tracks which cores are busy and which key each holds, and on the first successful decryption latches that core's key and asserts a global stop. If the key range is exhausted with no hit, it reports failure.

---
 rtl/key_search_if.sv | 30 +++
 rtl/key_search_scheduler.sv | 142 ++++++++++++++
 tb/tb_key_search_scheduler.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/key_search_if.sv
// Key scheduler bundle shared by search control, decrypt cores and scheduler.
// The scheduler side uses the slave modport.
interface key_search_if #(
   parameter int NUM_CORES = 4,
   parameter int KEY_WIDTH = 24
);
   logic                 start;
   logic [NUM_CORES-1:0] core_req;
   logic [NUM_CORES-1:0] core_done;
   logic [NUM_CORES-1:0] core_found;
   logic [NUM_CORES-1:0] grant;
   logic [KEY_WIDTH-1:0] grant_key;
   logic [NUM_CORES-1:0] busy;
   logic                 stop_search;
   logic                 key_found;
   logic [KEY_WIDTH-1:0] found_key;
   logic                 exhausted;

   modport master (
      output start, core_req, core_done, core_found,
      input  grant, grant_key, busy,
      input  stop_search, key_found, found_key, exhausted
   );

   modport slave (
      input  start, core_req, core_done, core_found,
      output grant, grant_key, busy,
      output stop_search, key_found, found_key, exhausted
   );
endinterface

// File: rtl/key_search_scheduler.sv
// Round-robin RC4 key dispatcher: hands untried keys to idle cores,
// latches the first winning key or flags an exhausted range.
module key_search_scheduler #(
   parameter int                   NUM_CORES = 4,
   parameter int                   KEY_WIDTH = 24,
   parameter logic [KEY_WIDTH-1:0] KEY_MIN   = '0,
   parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF
) (
   input logic         clk,
   input logic         reset,
   key_search_if.slave bus
);
   localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_DISPATCH, S_DRAIN, S_FOUND, S_EXHAUSTED
   } state_t;

   state_t               state, state_d;
   logic [PW-1:0]        rr_ptr, rr_d;
   logic [KEY_WIDTH-1:0] next_key, nk_d;
   logic [NUM_CORES-1:0] busy_q, busy_d;
   logic [KEY_WIDTH-1:0] key_q [NUM_CORES];
   logic [KEY_WIDTH-1:0] key_d [NUM_CORES];
   logic [NUM_CORES-1:0] grant_q, grant_d;
   logic [KEY_WIDTH-1:0] gk_q, gk_d;
   logic [KEY_WIDTH-1:0] fk_q, fk_d;
   logic                 kf_q, kf_d;
   logic                 stop_q, stop_d;
   logic                 exh_q, exh_d;

   logic [NUM_CORES-1:0] valid_done, hit;
   logic [PW-1:0]        hit_idx, gnt_idx;
   logic                 gnt_ok;

   assign valid_done = bus.core_done & busy_q;
   assign hit        = valid_done & bus.core_found;

   // Lowest-numbered winner takes the found key.
   always_comb begin
      hit_idx = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (hit[i]) hit_idx = PW'(i);
      end
   end

   always_comb begin
      gnt_ok  = 1'b0;
      gnt_idx = '0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         if (bus.core_req[(int'(rr_ptr) + k) % NUM_CORES] &&
             !busy_q[(int'(rr_ptr) + k) % NUM_CORES]) begin
            gnt_ok  = 1'b1;
            gnt_idx = PW'((int'(rr_ptr) + k) % NUM_CORES);
         end
      end
   end

   always_comb begin
      state_d = state;
      rr_d    = rr_ptr;
      nk_d    = next_key;
      busy_d  = busy_q & ~valid_done;
      key_d   = key_q;
      grant_d = '0;
      gk_d    = gk_q;
      fk_d    = fk_q;
      kf_d    = kf_q;
      stop_d  = stop_q;
      exh_d   = exh_q;
      unique case (state)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_DISPATCH;
               nk_d    = KEY_MIN;
               rr_d    = '0;
            end
         end
         S_DISPATCH, S_DRAIN: begin
            if (|hit) begin
               state_d = S_FOUND;
               fk_d    = key_q[hit_idx];
               kf_d    = 1'b1;
               stop_d  = 1'b1;
               busy_d  = '0;
            end else if (state == S_DISPATCH) begin
               if (gnt_ok) begin
                  grant_d[gnt_idx] = 1'b1;
                  gk_d             = next_key;
                  key_d[gnt_idx]   = next_key;
                  busy_d[gnt_idx]  = 1'b1;
                  rr_d = (gnt_idx == PW'(NUM_CORES - 1)) ?
                         '0 : gnt_idx + 1'b1;
                  if (next_key == KEY_MAX) state_d = S_DRAIN;
                  else nk_d = next_key + 1'b1;
               end
            end else if (busy_d == '0) begin
               state_d = S_EXHAUSTED;
               exh_d   = 1'b1;
               stop_d  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         rr_ptr   <= '0;
         next_key <= KEY_MIN;
         busy_q   <= '0;
         key_q    <= '{default: '0};
         grant_q  <= '0;
         gk_q     <= '0;
         fk_q     <= '0;
         kf_q     <= 1'b0;
         stop_q   <= 1'b0;
         exh_q    <= 1'b0;
      end else begin
         state    <= state_d;
         rr_ptr   <= rr_d;
         next_key <= nk_d;
         busy_q   <= busy_d;
         key_q    <= key_d;
         grant_q  <= grant_d;
         gk_q     <= gk_d;
         fk_q     <= fk_d;
         kf_q     <= kf_d;
         stop_q   <= stop_d;
         exh_q    <= exh_d;
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_key   = gk_q;
   assign bus.busy        = busy_q;
   assign bus.found_key   = fk_q;
   assign bus.key_found   = kf_q;
   assign bus.stop_search = stop_q;
   assign bus.exhausted   = exh_q;
endmodule

// File: tb/tb_key_search_scheduler.sv
// Directed bench: full-range scheduler (hits) and KEY_MAX=5 scheduler
// (reset restart, drain, exhaustion).
module tb_key_search_scheduler;
   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   key_search_if #(.NUM_CORES(4), .KEY_WIDTH(24)) ia ();
   key_search_if #(.NUM_CORES(4), .KEY_WIDTH(24)) ib ();

   key_search_scheduler u_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ia.slave)
   );

   key_search_scheduler #(
      .NUM_CORES (4),
      .KEY_WIDTH (24),
      .KEY_MIN   (24'd0),
      .KEY_MAX   (24'd5)
   ) u_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ib.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      ib.start = 1'b0; ib.core_req = '0;
      ib.core_done = '0; ib.core_found = '0;
      for (int i = 0; i < 2; i++) begin
         ia.start      = 1'($urandom);
         ia.core_req   = 4'($urandom);
         ia.core_done  = 4'($urandom);
         ia.core_found = 4'($urandom);
         tick();
      end
      chk("rst_grant", 32'(ia.grant), 0);
      chk("rst_gkey", 32'(ia.grant_key), 0);
      chk("rst_busy", 32'(ia.busy), 0);
      chk("rst_stop", 32'(ia.stop_search), 0);
      chk("rst_kf", 32'(ia.key_found), 0);
      chk("rst_fkey", 32'(ia.found_key), 0);
      chk("rst_exh", 32'(ia.exhausted), 0);

      reset = 1'b0;
      ia.start = 1'b0; ia.core_req = 4'b1111;
      ia.core_done = '0; ia.core_found = '0;
      tick();
      chk("idle_nogrant", 32'(ia.grant), 0);
      ia.start = 1'b1;
      tick();
      chk("start_nogrant", 32'(ia.grant), 0);
      ia.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("fan_grant", 32'(ia.grant), 32'(1 << i));
         chk("fan_key", 32'(ia.grant_key), 32'(i));
      end
      chk("fan_busy", 32'(ia.busy), 32'hF);
      tick();
      chk("no_regrant", 32'(ia.grant), 0);

      ia.core_done = 4'b0100;
      tick();
      chk("rot_busy", 32'(ia.busy), 32'hB);
      chk("rot_nogrant", 32'(ia.grant), 0);
      ia.core_done = '0;
      tick();
      chk("rot_grant", 32'(ia.grant), 32'h4);
      chk("rot_key", 32'(ia.grant_key), 4);

      ia.core_done = 4'b1010;
      tick();
      chk("free13_busy", 32'(ia.busy), 32'h5);
      ia.core_done = '0;
      tick();
      chk("rr3_grant", 32'(ia.grant), 32'h8);
      chk("rr3_key", 32'(ia.grant_key), 5);
      tick();
      chk("rr0_grant", 32'(ia.grant), 32'h2);
      chk("rr0_key", 32'(ia.grant_key), 6);

      ia.core_done = 4'b0001;
      tick();
      chk("free0_busy", 32'(ia.busy), 32'hE);
      ia.core_done = 4'b1001; ia.core_found = 4'b1001;
      tick();
      chk("hit_nogrant", 32'(ia.grant), 0);
      chk("hit_fkey", 32'(ia.found_key), 5);
      chk("hit_kf", 32'(ia.key_found), 1);
      chk("hit_stop", 32'(ia.stop_search), 1);
      chk("hit_busy", 32'(ia.busy), 0);
      for (int i = 0; i < 3; i++) begin
         ia.start      = 1'($urandom);
         ia.core_req   = 4'($urandom);
         ia.core_done  = 4'($urandom);
         ia.core_found = 4'($urandom);
         tick();
         chk("term_grant", 32'(ia.grant), 0);
         chk("term_fkey", 32'(ia.found_key), 5);
         chk("term_exh", 32'(ia.exhausted), 0);
      end

      reset = 1'b1;
      ia.start = 1'b0; ia.core_req = '0;
      ia.core_done = '0; ia.core_found = '0;
      tick();
      chk("rst2_kf", 32'(ia.key_found), 0);
      chk("rst2_fkey", 32'(ia.found_key), 0);
      reset = 1'b0;
      ia.core_req = 4'b1111; ia.start = 1'b1;
      tick();
      ia.start = 1'b0;
      repeat (4) tick();
      chk("sim_lastkey", 32'(ia.grant_key), 3);
      ia.core_done = 4'b1010; ia.core_found = 4'b1010;
      tick();
      chk("sim_fkey", 32'(ia.found_key), 1);
      chk("sim_kf", 32'(ia.key_found), 1);
      ia.core_done = '0; ia.core_found = '0; ia.core_req = '0;

      ib.core_req = 4'b1111; ib.start = 1'b1;
      tick();
      ib.start = 1'b0;
      tick();
      tick();
      chk("b_pre_key", 32'(ib.grant_key), 1);
      reset = 1'b1;
      tick();
      chk("b_rst_grant", 32'(ib.grant), 0);
      chk("b_rst_busy", 32'(ib.busy), 0);
      chk("b_rst_gkey", 32'(ib.grant_key), 0);
      reset = 1'b0;
      tick();
      chk("b_idle_nogrant", 32'(ib.grant), 0);
      ib.start = 1'b1;
      tick();
      ib.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("b_fan_grant", 32'(ib.grant), 32'(1 << i));
         chk("b_fan_key", 32'(ib.grant_key), 32'(i));
      end
      ib.core_done = 4'b0011;
      tick();
      chk("b_free_busy", 32'(ib.busy), 32'hC);
      ib.core_done = '0;
      tick();
      chk("b_k4_grant", 32'(ib.grant), 32'h1);
      chk("b_k4_key", 32'(ib.grant_key), 4);
      tick();
      chk("b_k5_grant", 32'(ib.grant), 32'h2);
      chk("b_k5_key", 32'(ib.grant_key), 5);
      ib.core_done = 4'b0001;
      tick();
      ib.core_done = '0;
      tick();
      chk("drain_nogrant", 32'(ib.grant), 0);
      chk("drain_key", 32'(ib.grant_key), 5);
      chk("drain_exh", 32'(ib.exhausted), 0);
      chk("drain_stop", 32'(ib.stop_search), 0);
      ib.core_done = 4'b1110;
      tick();
      chk("exh_flag", 32'(ib.exhausted), 1);
      chk("exh_stop", 32'(ib.stop_search), 1);
      chk("exh_kf", 32'(ib.key_found), 0);
      chk("exh_busy", 32'(ib.busy), 0);
      ib.core_done = '0;
      tick();
      chk("exh_nogrant", 32'(ib.grant), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
